// File: rtl/result_pkg.sv
// Shared types and constants for the result port arbiter.
package result_pkg;

  // Default parameter values
  localparam int DWIDTH_DEF    = 40;
  localparam int AWIDTH_DEF    = 2;
  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;

  // Requester index is wide enough for up to 8 requesters.
  // The burst counter is wide enough for a burst length of up to 15.
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Encode a one-hot vector (zero-extended to 8 bits) into an index
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [7:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) begin
        idx = 3'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/result_arb_pick.sv
// Owner selection: first requesting index found when the search starts at ptr
// and wraps around modulo NUM_REQ. A pointer of 0 gives plain lowest-index priority.
module result_arb_pick
  import result_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);

  logic [CNT_W-1:0] pos_s;
  logic             found_s;

  // Walk the request vector from ptr, wrapping once, and keep the first hit
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    pos_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos_s = {1'b0, ptr} + CNT_W'(i);
      if (pos_s >= CNT_W'(NUM_REQ)) begin
        pos_s = pos_s - CNT_W'(NUM_REQ);
      end else begin
        pos_s = pos_s;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found_s && req[k] && (pos_s == CNT_W'(k))) begin
          pick[k] = 1'b1;
          found_s = 1'b1;
        end else begin
          pick[k] = pick[k];
        end
      end
    end
  end

endmodule

// File: rtl/result_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto one BRAM port with burst-limited ownership.
// Optional macro RESULT_ARB_ROUND_ROBIN_EN: round-robin owner selection; otherwise
// lowest index wins at every arbitration and the burst cap hands one beat onward.
module result_port_arbiter
  import result_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int AWIDTH    = AWIDTH_DEF,
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*AWIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DWIDTH-1:0] d_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DWIDTH-1:0]         q_o,
  input  logic [DWIDTH-1:0]         q_b_i,
  output logic [AWIDTH-1:0]         addr_b_o,
  output logic                      ce_b_o,
  output logic                      we_b_o,
  output logic [DWIDTH-1:0]         d_b_o
);

  localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] HOT0      = NUM_REQ'(1);

  arb_state_t          state_r, state_n;
  logic [IDX_W-1:0]    owner_r, owner_n;
  logic [IDX_W-1:0]    ptr_r, ptr_n;
  logic [CNT_W-1:0]    count_r, count_n;
  logic [NUM_REQ-1:0]  own_hot_s, pick_req_s, pick_s, gnt_s;
  logic [IDX_W-1:0]    gnt_idx_s;
  logic                sel_we_s;
  logic [AWIDTH-1:0]   sel_addr_s;
  logic [DWIDTH-1:0]   sel_d_s;
  logic                rd1_valid_r, rd2_valid_r;
  logic [IDX_W-1:0]    rd1_idx_r, rd2_idx_r;
`ifdef RESULT_ARB_ROUND_ROBIN_EN
  logic                stay_s;
`else
  logic                cap_s;
`endif

  // Build the request vector handed to the picker (capped owner excluded when others wait)
  always_comb begin
    own_hot_s = HOT0 << owner_r;
`ifdef RESULT_ARB_ROUND_ROBIN_EN
    stay_s     = (state_r == OWN) && (|(req_i & own_hot_s)) && (count_r < BURST_MAX);
    pick_req_s = req_i;
`else
    cap_s = (state_r == OWN) && (count_r >= BURST_MAX);
    if (cap_s && (|(req_i & ~own_hot_s))) begin
      pick_req_s = req_i & ~own_hot_s;
    end else begin
      pick_req_s = req_i;
    end
`endif
  end

  result_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req  (pick_req_s),
    .ptr  (ptr_r),
    .pick (pick_s)
  );

  // Combinational one-hot grant; held at zero while reset is asserted
  always_comb begin
    gnt_s = '0;
    if (reset) begin
      gnt_s = '0;
    end
`ifdef RESULT_ARB_ROUND_ROBIN_EN
    else if (stay_s) begin
      gnt_s = own_hot_s;
    end
`endif
    else begin
      gnt_s = pick_s;
    end
  end

  assign gnt_o     = gnt_s;
  assign gnt_idx_s = onehot_to_idx(8'(gnt_s));

  // Ownership FSM next state: owner, burst counter and search pointer
  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
    count_n = count_r;
    ptr_n   = ptr_r;
    case (state_r)
      IDLE: begin
        if (|gnt_s) begin
          state_n = OWN;
          owner_n = gnt_idx_s;
          count_n = 4'd1;
        end else begin
          count_n = 4'd0;
        end
      end
      OWN: begin
        if (|gnt_s) begin
          owner_n = gnt_idx_s;
          if ((gnt_idx_s == owner_r) && (count_r < BURST_MAX)) begin
            count_n = count_r + 4'd1;
          end else begin
            count_n = 4'd1;
          end
        end else begin
          state_n = IDLE;
          count_n = 4'd0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = 4'd0;
      end
    endcase
`ifdef RESULT_ARB_ROUND_ROBIN_EN
    if (|gnt_s) begin
      ptr_n = (gnt_idx_s == LAST_IDX) ? 3'd0 : (gnt_idx_s + 3'd1);
    end else begin
      ptr_n = ptr_r;
    end
`else
    ptr_n = 3'd0;
`endif
  end

  // Ownership FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      owner_r <= 3'd0;
      count_r <= 4'd0;
      ptr_r   <= 3'd0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      count_r <= count_n;
      ptr_r   <= ptr_n;
    end
  end

  // One-hot mux of the granted requester's command fields
  always_comb begin
    sel_we_s   = 1'b0;
    sel_addr_s = '0;
    sel_d_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_we_s   = sel_we_s | (gnt_s[k] & we_i[k]);
      sel_addr_s = sel_addr_s | ({AWIDTH{gnt_s[k]}} & addr_i[k*AWIDTH +: AWIDTH]);
      sel_d_s    = sel_d_s | ({DWIDTH{gnt_s[k]}} & d_i[k*DWIDTH +: DWIDTH]);
    end
  end

  // Register the granted beat onto BRAM port B; address and data hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_b_o   <= 1'b0;
      we_b_o   <= 1'b0;
      addr_b_o <= '0;
      d_b_o    <= '0;
    end else if (|gnt_s) begin
      ce_b_o   <= 1'b1;
      we_b_o   <= sel_we_s;
      addr_b_o <= sel_addr_s;
      d_b_o    <= sel_d_s;
    end else begin
      ce_b_o   <= 1'b0;
      we_b_o   <= 1'b0;
    end
  end

  // Two-stage read tracker: stage 2 lines up with BRAM read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_valid_r <= 1'b0;
      rd1_idx_r   <= 3'd0;
      rd2_valid_r <= 1'b0;
      rd2_idx_r   <= 3'd0;
    end else begin
      rd1_valid_r <= (|gnt_s) & ~sel_we_s;
      rd1_idx_r   <= gnt_idx_s;
      rd2_valid_r <= rd1_valid_r;
      rd2_idx_r   <= rd1_idx_r;
    end
  end

  // Steer the returning read data to the requester that issued it
  always_comb begin
    rvalid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rvalid_o[k] = rd2_valid_r && (rd2_idx_r == IDX_W'(k));
    end
    if (rd2_valid_r) begin
      q_o = q_b_i;
    end else begin
      q_o = '0;
    end
  end

endmodule

// File: tb/tb_result_port_arbiter.sv
// Directed bench for result_port_arbiter with a behavioural 1-cycle BRAM on port B.
module tb_result_port_arbiter;

  localparam int DW = 40;
  localparam int AW = 2;
  localparam int NR = 4;

  logic           clk;
  logic           reset;
  logic [NR-1:0]  req_i, we_i;
  logic [NR*AW-1:0] addr_i;
  logic [NR*DW-1:0] d_i;
  logic [NR-1:0]  gnt_o, rvalid_o;
  logic [DW-1:0]  q_o, q_b_i, d_b_o;
  logic [AW-1:0]  addr_b_o;
  logic           ce_b_o, we_b_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mem [4];

  result_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .d_i      (d_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .q_o      (q_o),
    .q_b_i    (q_b_i),
    .addr_b_o (addr_b_o),
    .ce_b_o   (ce_b_o),
    .we_b_o   (we_b_o),
    .d_b_o    (d_b_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: synchronous write, registered read (latency 1)
  always @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      mem[2] <= '0;
      mem[3] <= 40'hAB00000031;
      q_b_i  <= '0;
    end else if (ce_b_o) begin
      if (we_b_o) mem[addr_b_o] <= d_b_o;
      else        q_b_i <= mem[addr_b_o];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"},    64'(gnt_o),    64'h0);
    chk({tag, " ce"},     64'(ce_b_o),   64'h0);
    chk({tag, " we"},     64'(we_b_o),   64'h0);
    chk({tag, " addr"},   64'(addr_b_o), 64'h0);
    chk({tag, " d"},      64'(d_b_o),    64'h0);
    chk({tag, " rvalid"}, 64'(rvalid_o), 64'h0);
    chk({tag, " q"},      64'(q_o),      64'h0);
  endtask

  typedef struct {
    logic [3:0]   req;
    logic [3:0]   we;
    logic [7:0]   addr;
    logic [159:0] d;
    logic [3:0]   gnt;
    logic         ce;
    logic         bwe;
    logic [1:0]   baddr;
    logic [39:0]  bd;
    logic [3:0]   rv;
    logic [39:0]  q;
  } vec_t;

  vec_t       vecs [12];
  logic [3:0] burst_exp [12];

  initial begin
    // Each record: inputs this cycle, gnt expected this cycle, and the BRAM
    // port / read return expected in this same cycle (from earlier grants).
    vecs[0]  = '{4'b0001, 4'b0001, 8'h01, {120'h0, 40'h1F},          4'b0001, 1'b0, 1'b0, 2'd0, 40'h0,          4'b0000, 40'h0};
    vecs[1]  = '{4'b0000, 4'b0000, 8'h00, 160'h0,                    4'b0000, 1'b1, 1'b1, 2'd1, 40'h1F,         4'b0000, 40'h0};
    vecs[2]  = '{4'b1000, 4'b1000, 8'h80, {40'h5500000001, 120'h0},  4'b1000, 1'b0, 1'b0, 2'd1, 40'h1F,         4'b0000, 40'h0};
    vecs[3]  = '{4'b0100, 4'b0000, 8'h30, 160'h0,                    4'b0100, 1'b1, 1'b1, 2'd2, 40'h5500000001, 4'b0000, 40'h0};
    vecs[4]  = '{4'b0010, 4'b0010, 8'h00, {80'h0, 40'h0123456789, 40'h0}, 4'b0010, 1'b1, 1'b0, 2'd3, 40'h0,     4'b0000, 40'h0};
    vecs[5]  = '{4'b0000, 4'b0000, 8'h00, 160'h0,                    4'b0000, 1'b1, 1'b1, 2'd0, 40'h0123456789, 4'b0100, 40'hAB00000031};
    vecs[6]  = '{4'b0000, 4'b0000, 8'h00, 160'h0,                    4'b0000, 1'b0, 1'b0, 2'd0, 40'h0123456789, 4'b0000, 40'h0};
    vecs[7]  = '{4'b0001, 4'b0000, 8'h01, 160'h0,                    4'b0001, 1'b0, 1'b0, 2'd0, 40'h0123456789, 4'b0000, 40'h0};
    vecs[8]  = '{4'b0010, 4'b0000, 8'h08, 160'h0,                    4'b0010, 1'b1, 1'b0, 2'd1, 40'h0,          4'b0000, 40'h0};
    vecs[9]  = '{4'b0000, 4'b0000, 8'h00, 160'h0,                    4'b0000, 1'b1, 1'b0, 2'd2, 40'h0,          4'b0001, 40'h1F};
    vecs[10] = '{4'b0000, 4'b0000, 8'h00, 160'h0,                    4'b0000, 1'b0, 1'b0, 2'd2, 40'h0,          4'b0010, 40'h5500000001};
    vecs[11] = '{4'b0000, 4'b0000, 8'h00, 160'h0,                    4'b0000, 1'b0, 1'b0, 2'd2, 40'h0,          4'b0000, 40'h0};

`ifdef RESULT_ARB_ROUND_ROBIN_EN
    burst_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                  4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    burst_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001,
                  4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
`endif

    // Reset state
    reset  = 1'b1;
    req_i  = '0;
    we_i   = '0;
    addr_i = '0;
    d_i    = '0;
    #2;
    chk_all_zero("reset");
    req_i = 4'b1111;
    #1;
    chk("reset gnt gated", 64'(gnt_o), 64'h0);
    req_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven single-beat traffic
    for (int i = 0; i < 12; i++) begin
      req_i  = vecs[i].req;
      we_i   = vecs[i].we;
      addr_i = vecs[i].addr;
      d_i    = vecs[i].d;
      @(negedge clk);
      chk($sformatf("v%0d gnt", i),    64'(gnt_o),    64'(vecs[i].gnt));
      chk($sformatf("v%0d ce", i),     64'(ce_b_o),   64'(vecs[i].ce));
      chk($sformatf("v%0d we", i),     64'(we_b_o),   64'(vecs[i].bwe));
      chk($sformatf("v%0d addr", i),   64'(addr_b_o), 64'(vecs[i].baddr));
      chk($sformatf("v%0d d", i),      64'(d_b_o),    64'(vecs[i].bd));
      chk($sformatf("v%0d rvalid", i), 64'(rvalid_o), 64'(vecs[i].rv));
      if (vecs[i].rv != 4'b0000) begin
        chk($sformatf("v%0d q", i), 64'(q_o), 64'(vecs[i].q));
      end
      @(posedge clk); #1;
    end

    // Burst cap with two requesters held continuously
    req_i  = 4'b0011;
    we_i   = 4'b0011;
    addr_i = '0;
    d_i    = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("burst c%0d gnt", c), 64'(gnt_o), 64'(burst_exp[c]));
      @(posedge clk); #1;
    end
    req_i = '0;
    we_i  = '0;
    @(posedge clk); #1;

    // Lone requester past the cap keeps the port
    req_i = 4'b0100;
    we_i  = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("hold c%0d gnt", c), 64'(gnt_o), 64'h4);
      @(posedge clk); #1;
    end
    req_i = '0;
    we_i  = '0;
    @(posedge clk); #1;

    // Reset one cycle after a read grant drops the read
    req_i  = 4'b0001;
    we_i   = 4'b0000;
    addr_i = 8'h03;
    @(negedge clk);
    chk("rstrd grant", 64'(gnt_o), 64'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_all_zero("rstrd");
    req_i = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstrd post c%0d rvalid", c), 64'(rvalid_o), 64'h0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
